// File: rtl/weight_skew_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : weight_skew_buffer_pkg
//  Description : Shared FSM encoding and width/length helpers for the skew buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package weight_skew_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_READY = 2'd2,
        ST_DRAIN = 2'd3
    } wsb_state_e;

    function automatic int wsb_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int wsb_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Beats from the first pop to the last column's last beat, minus one.
    function automatic int wsb_drain_len(input int depth, input int cols);
        return depth + cols - 1;
    endfunction

    function automatic int wsb_drain_cnt_w(input int depth, input int cols);
        return $clog2(depth + cols);
    endfunction

endpackage
`default_nettype wire

// File: rtl/weight_skew_buffer_skew_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : skew_delay_line
//  Description : Registered {en, data} shift line, DELAY+1 flops deep.
//  Revision    : 1.0 - initial release
// ============================================================================
module skew_delay_line
    import weight_skew_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DELAY      = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  in_en,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_en,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int STAGES = DELAY + 1;

    logic [STAGES-1:0]     en_q, en_d;
    logic [DATA_WIDTH-1:0] data_q [STAGES];
    logic [DATA_WIDTH-1:0] data_d [STAGES];

    // Data is masked at entry so an idle slot always carries zero downstream.
    always_comb begin
        en_d = '0;
        for (int i = 0; i < STAGES; i++) begin
            data_d[i] = '0;
        end
        if (!clear) begin
            en_d[0]   = in_en;
            data_d[0] = in_en ? in_data : '0;
            for (int i = 1; i < STAGES; i++) begin
                en_d[i]   = en_q[i-1];
                data_d[i] = data_q[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            en_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            en_q <= en_d;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_en   = en_q[STAGES-1];
    assign out_data = data_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/weight_skew_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : weight_skew_buffer
//  Description : One-tile weight row buffer draining into the PE array with
//                optional per-column diagonal skew.
//  Revision    : 1.0 - initial release
// ============================================================================
module weight_skew_buffer
    import weight_skew_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_COLS   = 4,
    parameter int DEPTH      = 4,
    parameter bit SKEW_EN    = 1'b1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH*NUM_COLS-1:0] in_data,
    input  logic                           start,
    input  logic                           clear,
    output logic                           busy,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty,
    output logic [NUM_COLS-1:0]            out_en,
    output logic [DATA_WIDTH*NUM_COLS-1:0] out_data,
    output logic                           done
);

    localparam int ROW_W  = DATA_WIDTH * NUM_COLS;
    localparam int PTR_W  = wsb_ptr_w(DEPTH);
    localparam int CNT_W  = wsb_cnt_w(DEPTH);
    localparam int DRN_W  = wsb_drain_cnt_w(DEPTH, NUM_COLS);
    localparam int LAST_I = SKEW_EN ? wsb_drain_len(DEPTH, NUM_COLS) : DEPTH;

    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_M1   = CNT_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_MAX    = PTR_W'(DEPTH - 1);
    localparam logic [DRN_W-1:0] POP_END    = DRN_W'(DEPTH);
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(LAST_I);

    wsb_state_e        state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DRN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ROW_W-1:0]  mem_q [DEPTH];
    logic [ROW_W-1:0]  mem_d [DEPTH];

    logic              push;
    logic              pop;
    logic              last_beat;
    logic [ROW_W-1:0]  pop_row;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign in_ready  = reset && (state_q != ST_DRAIN) && !full && !clear;
    assign push      = in_valid && in_ready;
    // drain_cnt_q counts edges since DRAIN entry; the first DEPTH of them pop.
    assign pop       = (state_q == ST_DRAIN) && (drain_cnt_q < POP_END) && !clear;
    assign last_beat = (state_q == ST_DRAIN) && (drain_cnt_q == DRAIN_LAST);
    assign pop_row   = pop ? mem_q[rd_ptr_q] : '0;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (push) state_d = ST_FILL;
            ST_FILL:  if (push && (count_q == DEPTH_M1)) state_d = ST_READY;
            ST_READY: if (start) state_d = ST_DRAIN;
            ST_DRAIN: if (last_beat) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (clear) begin
            state_d = ST_IDLE;
        end
    end

    // Output / drain sequencing logic
    always_comb begin
        drain_cnt_d = '0;
        done_d      = 1'b0;
        busy_d      = (state_d == ST_DRAIN);
        if (!clear && (state_q == ST_DRAIN)) begin
            done_d = last_beat;
            if (!last_beat) begin
                drain_cnt_d = drain_cnt_q + 1'b1;
            end
        end
    end

    // Circular row storage; push and pop never coincide since DRAIN blocks push.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_data;
                wr_ptr_d        = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
                count_d         = count_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
                count_d  = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            drain_cnt_q <= drain_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign count = count_q;

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        skew_delay_line #(
            .DATA_WIDTH (DATA_WIDTH),
            .DELAY      (SKEW_EN ? c : 0)
        ) u_dly (
            .clock    (clock),
            .reset    (reset),
            .clear    (clear),
            .in_en    (pop),
            .in_data  (pop_row[c*DATA_WIDTH +: DATA_WIDTH]),
            .out_en   (out_en[c]),
            .out_data (out_data[c*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_weight_skew_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_weight_skew_buffer
//  Description : Scoreboard bench for skewed and aligned weight_skew_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_skew_buffer;

    localparam int D  = 4;
    localparam int NC = 4;

    typedef struct {
        int          cyc;
        logic [3:0]  en;
        logic [31:0] data;
        logic        done;
    } beat_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        s_in_valid, s_start, s_clear, s_in_ready, s_busy, s_full, s_empty, s_done;
    logic [31:0] s_in_data, s_out_data;
    logic [2:0]  s_count;
    logic [3:0]  s_out_en;
    logic        a_in_valid, a_start, a_clear, a_in_ready, a_busy, a_full, a_empty, a_done;
    logic [31:0] a_in_data, a_out_data;
    logic [2:0]  a_count;
    logic [3:0]  a_out_en;

    weight_skew_buffer #(.DATA_WIDTH(8), .NUM_COLS(NC), .DEPTH(D), .SKEW_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .start(s_start), .clear(s_clear), .busy(s_busy),
        .count(s_count), .full(s_full), .empty(s_empty), .out_en(s_out_en),
        .out_data(s_out_data), .done(s_done)
    );

    weight_skew_buffer #(.DATA_WIDTH(8), .NUM_COLS(NC), .DEPTH(D), .SKEW_EN(1'b0)) dut_al (
        .clock(clock), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .start(a_start), .clear(a_clear), .busy(a_busy),
        .count(a_count), .full(a_full), .empty(a_empty), .out_en(a_out_en),
        .out_data(a_out_data), .done(a_done)
    );

    int    cyc = 0;
    int    vectors = 0;
    int    errors = 0;
    beat_t sq[$];
    beat_t aq[$];
    beat_t sb, ab;
    logic [31:0] tile [4];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: cycle %0d got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Skew monitor: every presented beat or done pulse must match the queue head.
    always @(negedge clock) begin
        if (reset === 1'b1 && (s_out_en != 4'h0 || s_done)) begin
            vectors++;
            if (sq.size() == 0) begin
                errors++;
                $display("FAIL skew_unexpected: cycle %0d got en=%h data=%h done=%b expected no output",
                         cyc, s_out_en, s_out_data, s_done);
            end else begin
                sb = sq.pop_front();
                if (sb.cyc != cyc || sb.en !== s_out_en || sb.data !== s_out_data || sb.done !== s_done) begin
                    errors++;
                    $display("FAIL skew_beat: cycle %0d got en=%h data=%h done=%b expected cycle %0d en=%h data=%h done=%b",
                             cyc, s_out_en, s_out_data, s_done, sb.cyc, sb.en, sb.data, sb.done);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (reset === 1'b1 && (a_out_en != 4'h0 || a_done)) begin
            vectors++;
            if (aq.size() == 0) begin
                errors++;
                $display("FAIL align_unexpected: cycle %0d got en=%h data=%h done=%b expected no output",
                         cyc, a_out_en, a_out_data, a_done);
            end else begin
                ab = aq.pop_front();
                if (ab.cyc != cyc || ab.en !== a_out_en || ab.data !== a_out_data || ab.done !== a_done) begin
                    errors++;
                    $display("FAIL align_beat: cycle %0d got en=%h data=%h done=%b expected cycle %0d en=%h data=%h done=%b",
                             cyc, a_out_en, a_out_data, a_done, ab.cyc, ab.en, ab.data, ab.done);
                end
            end
        end
    end

    // Column c shows row r in cycle k+1+r+c; done one cycle after the last beat.
    task automatic exp_skew(input int k, input int last_t, input bit with_done);
        beat_t e;
        for (int t = k + 1; t <= last_t; t++) begin
            e.cyc = t; e.en = '0; e.data = '0; e.done = 1'b0;
            for (int c = 0; c < NC; c++) begin
                int r;
                r = t - k - 1 - c;
                if (r >= 0 && r < D) begin
                    e.en[c] = 1'b1;
                    e.data[c*8 +: 8] = tile[r][c*8 +: 8];
                end
            end
            if (e.en != 4'h0) sq.push_back(e);
        end
        if (with_done) begin
            e.cyc = k + D + NC; e.en = '0; e.data = '0; e.done = 1'b1;
            sq.push_back(e);
        end
    endtask

    task automatic exp_align(input int k);
        beat_t e;
        for (int r = 0; r < D; r++) begin
            e.cyc = k + 1 + r; e.en = 4'hF; e.data = tile[r]; e.done = 1'b0;
            aq.push_back(e);
        end
        e.cyc = k + D + 1; e.en = '0; e.data = '0; e.done = 1'b1;
        aq.push_back(e);
    endtask

    task automatic s_push(input logic [31:0] d);
        int n;
        n = 0;
        s_in_valid = 1'b1;
        s_in_data  = d;
        while (!s_in_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!s_in_ready) begin
            vectors++; errors++;
            $display("FAIL push_timeout: in_ready got 0 expected 1 within 20 cycles");
        end
        @(negedge clock);
        s_in_valid = 1'b0;
    endtask

    task automatic a_push(input logic [31:0] d);
        int n;
        n = 0;
        a_in_valid = 1'b1;
        a_in_data  = d;
        while (!a_in_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!a_in_ready) begin
            vectors++; errors++;
            $display("FAIL align_push_timeout: in_ready got 0 expected 1 within 20 cycles");
        end
        @(negedge clock);
        a_in_valid = 1'b0;
    endtask

    // Called at a negedge; start is sampled at the following edge k.
    task automatic s_go(output int k, input bit cleared);
        s_start = 1'b1;
        k = cyc + 1;
        if (cleared) exp_skew(k, k + 2, 1'b0);
        else         exp_skew(k, k + D + NC - 1, 1'b1);
        @(negedge clock);
        s_start = 1'b0;
    endtask

    initial begin
        int          k, idx, acc, bad;
        bit          took;
        logic [31:0] bp [6];

        reset = 1'b0;
        s_in_valid = 0; s_start = 0; s_clear = 0; s_in_data = '0;
        a_in_valid = 0; a_start = 0; a_clear = 0; a_in_data = '0;
        repeat (3) @(negedge clock);
        chk("reset_in_ready", {31'd0, s_in_ready}, 32'd0);
        chk("reset_count",    {29'd0, s_count},    32'd0);
        chk("reset_empty",    {31'd0, s_empty},    32'd1);
        chk("reset_full",     {31'd0, s_full},     32'd0);
        chk("reset_busy",     {31'd0, s_busy},     32'd0);
        chk("reset_out_en",   {28'd0, s_out_en},   32'd0);
        chk("reset_done",     {31'd0, s_done},     32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("idle_in_ready", {31'd0, s_in_ready}, 32'd1);
        chk("idle_count",    {29'd0, s_count},    32'd0);
        chk("idle_empty",    {31'd0, s_empty},    32'd1);

        // Fill and skewed drain
        tile = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
        for (int i = 0; i < 4; i++) s_push(tile[i]);
        chk("fill_full",     {31'd0, s_full},     32'd1);
        chk("fill_count",    {29'd0, s_count},    32'd4);
        chk("fill_in_ready", {31'd0, s_in_ready}, 32'd0);
        s_go(k, 1'b0);
        chk("drain_busy", {31'd0, s_busy}, 32'd1);
        @(negedge clock);
        chk("col0_row0", {24'd0, s_out_data[7:0]}, 32'h01);
        repeat (3) @(negedge clock);
        chk("col0_row3", {24'd0, s_out_data[7:0]},   32'h0D);
        chk("col3_row0", {24'd0, s_out_data[31:24]}, 32'h04);
        repeat (4) @(negedge clock);
        chk("drain_done", {31'd0, s_done}, 32'd1);
        @(negedge clock);
        chk("after_busy",  {31'd0, s_busy},  32'd0);
        chk("after_count", {29'd0, s_count}, 32'd0);
        chk("after_done",  {31'd0, s_done},  32'd0);

        // Back-pressure with in_valid held high
        bp = '{32'h14131211, 32'h18171615, 32'h1C1B1A19, 32'h201F1E1D, 32'h24232221, 32'h28272625};
        idx = 0; acc = 0; bad = 0;
        s_in_valid = 1'b1; s_in_data = bp[0];
        for (int i = 0; i < 8; i++) begin
            took = s_in_ready;
            @(negedge clock);
            if (took) begin acc++; idx++; s_in_data = bp[idx]; end
        end
        chk("bp_accepted_full", acc, 32'd4);
        chk("bp_in_ready_full", {31'd0, s_in_ready}, 32'd0);
        tile = '{bp[0], bp[1], bp[2], bp[3]};
        s_start = 1'b1;
        k = cyc + 1;
        exp_skew(k, k + D + NC - 1, 1'b1);
        for (int i = 0; i < 14; i++) begin
            took = s_in_ready && s_in_valid;
            if (cyc < k + D + NC && s_in_ready) bad++;
            @(negedge clock);
            s_start = 1'b0;
            if (took) begin
                acc++; idx++;
                if (idx < 6) s_in_data = bp[idx];
                else         s_in_valid = 1'b0;
            end
        end
        chk("bp_ready_in_drain", bad, 32'd0);
        chk("bp_accepted_all",   acc, 32'd6);
        chk("bp_count_after",    {29'd0, s_count}, 32'd2);

        // Premature start with two rows stored
        s_start = 1'b1;
        @(negedge clock);
        s_start = 1'b0;
        repeat (6) @(negedge clock);
        chk("early_busy",  {31'd0, s_busy},  32'd0);
        chk("early_count", {29'd0, s_count}, 32'd2);

        // Complete the tile; rows 5-6 must come out first, uncorrupted
        s_push(32'h2C2B2A29);
        s_push(32'h302F2E2D);
        chk("mix_full", {31'd0, s_full}, 32'd1);
        tile = '{bp[4], bp[5], 32'h2C2B2A29, 32'h302F2E2D};
        s_go(k, 1'b0);
        repeat (D + NC + 1) @(negedge clock);
        chk("mix_count", {29'd0, s_count}, 32'd0);

        // Clear mid-drain
        tile = '{32'hA4A3A2A1, 32'hB4B3B2B1, 32'hC4C3C2C1, 32'hD4D3D2D1};
        for (int i = 0; i < 4; i++) s_push(tile[i]);
        s_go(k, 1'b1);
        repeat (2) @(negedge clock);
        s_clear = 1'b1;
        @(negedge clock);
        s_clear = 1'b0;
        chk("clr_out_en", {28'd0, s_out_en}, 32'd0);
        chk("clr_count",  {29'd0, s_count},  32'd0);
        chk("clr_busy",   {31'd0, s_busy},   32'd0);
        chk("clr_empty",  {31'd0, s_empty},  32'd1);
        repeat (8) @(negedge clock);

        // Next full tile after clear
        tile = '{32'hE4E3E2E1, 32'hF4F3F2F1, 32'h55667788, 32'h99AABBCC};
        for (int i = 0; i < 4; i++) s_push(tile[i]);
        s_go(k, 1'b0);
        repeat (D + NC + 1) @(negedge clock);
        chk("post_clr_count", {29'd0, s_count}, 32'd0);

        // Aligned instance
        tile = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
        for (int i = 0; i < 4; i++) a_push(tile[i]);
        chk("al_full", {31'd0, a_full}, 32'd1);
        a_start = 1'b1;
        k = cyc + 1;
        exp_align(k);
        @(negedge clock);
        a_start = 1'b0;
        repeat (D + 3) @(negedge clock);
        chk("al_busy",  {31'd0, a_busy},  32'd0);
        chk("al_count", {29'd0, a_count}, 32'd0);

        repeat (3) @(negedge clock);
        while (sq.size() > 0) begin
            sb = sq.pop_front();
            vectors++; errors++;
            $display("FAIL skew_missing: beat for cycle %0d got nothing expected en=%h data=%h done=%b",
                     sb.cyc, sb.en, sb.data, sb.done);
        end
        while (aq.size() > 0) begin
            ab = aq.pop_front();
            vectors++; errors++;
            $display("FAIL align_missing: beat for cycle %0d got nothing expected en=%h data=%h done=%b",
                     ab.cyc, ab.en, ab.data, ab.done);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
